// File: rtl/cbb_pulse_spacer.sv
// Event-to-pulse spacer: queues incoming event strobes and re-emits them as
// registered pulses whose rising edges are at least P_GAP_CYCLES apart.
module cbb_pulse_spacer #(
  parameter int P_GAP_CYCLES = 6,
  parameter int P_OUT_WIDTH  = 1,
  parameter int P_CNT_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_event,
  input  logic               i_clr,
  input  logic               i_ovf_clr,
  output logic               o_pulse,
  output logic [P_CNT_W-1:0] o_pending,
  output logic               o_busy,
  output logic               o_overflow
);

  if (P_GAP_CYCLES < 2) begin : g_gap_chk
    $error("cbb_pulse_spacer: P_GAP_CYCLES must be >= 2");
  end
  if ((P_OUT_WIDTH < 1) || (P_OUT_WIDTH > P_GAP_CYCLES - 1)) begin : g_width_chk
    $error("cbb_pulse_spacer: P_OUT_WIDTH must be in 1..P_GAP_CYCLES-1");
  end

  localparam int LP_TW = $clog2(P_GAP_CYCLES);
  localparam logic [LP_TW-1:0]   LP_HIGH_LAST = LP_TW'(P_OUT_WIDTH - 1);
  localparam logic [LP_TW-1:0]   LP_GAP_LAST  = LP_TW'(P_GAP_CYCLES - P_OUT_WIDTH - 1);
  localparam logic [P_CNT_W-1:0] LP_CNT_MAX   = {P_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LP_TW-1:0]   r_timer;
  logic [LP_TW-1:0]   w_timer_nxt;
  logic [P_CNT_W-1:0] r_pending;
  logic [P_CNT_W-1:0] w_pending_nxt;
  logic               r_overflow;
  logic               w_overflow_nxt;
  logic               r_pulse;
  logic               w_high_last;
  logic               w_gap_last;
  logic               w_launch;
  logic               w_drop;

  // Launching is only legal from IDLE or in the final GAP cycle, which is
  // what enforces the spacing between consecutive pulse starts.
  always_comb begin
    w_high_last = (r_timer == LP_HIGH_LAST);
    w_gap_last  = (r_timer == LP_GAP_LAST);
    w_launch    = ((r_state == S_IDLE) || ((r_state == S_GAP) && w_gap_last)) &&
                  ((r_pending != '0) || i_event) && !i_clr;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_state_nxt = S_HIGH;
      S_HIGH: if (w_high_last) w_state_nxt = S_GAP;
      S_GAP:  if (w_gap_last) w_state_nxt = w_launch ? S_HIGH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) begin
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = r_timer + LP_TW'(1);
    end
  end

  // An event arriving in a launch cycle is consumed directly, so only the
  // non-launching cases can grow the queue or hit saturation.
  always_comb begin
    w_pending_nxt = r_pending;
    w_drop        = 1'b0;
    if (i_clr) begin
      w_pending_nxt = '0;
    end else if (w_launch) begin
      if (!i_event) begin
        w_pending_nxt = r_pending - P_CNT_W'(1);
      end
    end else if (i_event) begin
      if (r_pending == LP_CNT_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_pending_nxt = r_pending + P_CNT_W'(1);
      end
    end

    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (i_ovf_clr) begin
      w_overflow_nxt = 1'b0;
    end else begin
      w_overflow_nxt = r_overflow;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
      r_pulse    <= (w_state_nxt == S_HIGH);
    end
  end

  assign o_pulse    = r_pulse;
  assign o_pending  = r_pending;
  assign o_busy     = (r_state != S_IDLE) || (r_pending != '0);
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_cbb_pulse_spacer.sv
// Self-checking bench for cbb_pulse_spacer: two parameterisations driven from
// shared inputs and compared every cycle against a timeline-based model.
module tb_cbb_pulse_spacer;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic ev   = 1'b0;
  logic clr  = 1'b0;
  logic oc   = 1'b0;

  logic       pulse0, busy0, ovf0;
  logic [3:0] pend0;
  logic       pulse1, busy1, ovf1;
  logic [1:0] pend1;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  // Model: pulse timing is tracked only as the cycle of the last pulse start.
  int mG[2]   = '{6, 6};
  int mW[2]   = '{1, 3};
  int mMax[2] = '{15, 3};
  int mPend[2];
  int mOvf[2];
  int mLast[2];

  always #5 clk = ~clk;

  cbb_pulse_spacer u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_event(ev), .i_clr(clr), .i_ovf_clr(oc),
    .o_pulse(pulse0), .o_pending(pend0), .o_busy(busy0), .o_overflow(ovf0)
  );

  cbb_pulse_spacer #(.P_GAP_CYCLES(6), .P_OUT_WIDTH(3), .P_CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_event(ev), .i_clr(clr), .i_ovf_clr(oc),
    .o_pulse(pulse1), .o_pending(pend1), .o_busy(busy1), .o_overflow(ovf1)
  );

  function automatic int modelPulse(input int k);
    return ((t >= mLast[k]) && (t < mLast[k] + mW[k])) ? 1 : 0;
  endfunction

  function automatic int modelBusy(input int k);
    return ((t < mLast[k] + mG[k]) || (mPend[k] != 0)) ? 1 : 0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPend[k] = 0;
      mOvf[k]  = 0;
      mLast[k] = -1000;
    end
  endtask

  // A new pulse may start no sooner than G cycles after the previous start.
  task automatic modelClock(input bit e, input bit c, input bit o);
    for (int k = 0; k < 2; k++) begin
      bit launch;
      bit drop;
      launch = (t + 1 >= mLast[k] + mG[k]) && ((mPend[k] > 0) || e) && !c;
      drop   = 1'b0;
      if (c) mPend[k] = 0;
      else if (launch) begin
        if (!e) mPend[k]--;
      end else if (e) begin
        if (mPend[k] == mMax[k]) drop = 1'b1;
        else mPend[k]++;
      end
      if (drop) mOvf[k] = 1;
      else if (o) mOvf[k] = 0;
      if (launch) mLast[k] = t + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("[TB] FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("pulse0",   {31'd0, pulse0}, modelPulse(0));
    check("pending0", {28'd0, pend0},  mPend[0]);
    check("busy0",    {31'd0, busy0},  modelBusy(0));
    check("ovf0",     {31'd0, ovf0},   mOvf[0]);
    check("pulse1",   {31'd0, pulse1}, modelPulse(1));
    check("pending1", {30'd0, pend1},  mPend[1]);
    check("busy1",    {31'd0, busy1},  modelBusy(1));
    check("ovf1",     {31'd0, ovf1},   mOvf[1]);
  endtask

  task automatic applyStimulus(input bit e, input bit c, input bit o);
    @(negedge clk);
    checkOutput();
    ev  = e;
    clr = c;
    oc  = o;
    @(posedge clk);
    modelClock(e, c, o);
    t++;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_pulse0"}, {31'd0, pulse0}, 0);
    check({tag, "_pend0"},  {28'd0, pend0},  0);
    check({tag, "_busy0"},  {31'd0, busy0},  0);
    check({tag, "_ovf0"},   {31'd0, ovf0},   0);
    check({tag, "_pulse1"}, {31'd0, pulse1}, 0);
    check({tag, "_pend1"},  {30'd0, pend1},  0);
    check({tag, "_busy1"},  {31'd0, busy1},  0);
    check({tag, "_ovf1"},   {31'd0, ovf1},   0);
  endtask

  initial begin
    int found;
    modelReset();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rstn = 1'b1;

    // Single isolated event, then drain
    repeat (10) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (20) applyStimulus(0, 0, 0);

    // Three back-to-back events
    repeat (3) applyStimulus(1, 0, 0);
    repeat (25) applyStimulus(0, 0, 0);

    // Saturate both queues
    repeat (20) applyStimulus(1, 0, 0);
    #1;
    check("sat_pend1", {30'd0, pend1}, 3);
    check("sat_ovf0",  {31'd0, ovf0}, 1);
    check("sat_ovf1",  {31'd0, ovf1}, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    #1;
    check("ovfclr_ovf0", {31'd0, ovf0}, 0);
    check("ovfclr_ovf1", {31'd0, ovf1}, 0);
    repeat (110) applyStimulus(0, 0, 0);

    // Clear with a coincident event discards the queue
    repeat (3) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    #1;
    check("clr_pend0", {28'd0, pend0}, 0);
    check("clr_pend1", {30'd0, pend1}, 0);
    repeat (15) applyStimulus(0, 0, 0);

    // Random traffic
    repeat (300) begin
      applyStimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 5);
    end
    repeat (120) applyStimulus(0, 0, 0);

    // Async reset while a pulse is high with work still queued
    repeat (4) applyStimulus(1, 0, 0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (modelPulse(0) == 1) begin
        found = 1;
        break;
      end
      applyStimulus(0, 0, 0);
    end
    check("rst_wait", found, 1);
    #2;
    check("pre_rst_pulse0", {31'd0, pulse0}, 1);
    check("pre_rst_pend0",  {28'd0, pend0},  mPend[0]);
    rstn = 1'b0;
    #1;
    checkAllZero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    modelReset();
    repeat (15) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (10) applyStimulus(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
